load_store_unit: RTL and testbench

Core-side initiator for data-memory traffic: accepts one load/store request at a time from the execute stage, checks alignment, builds a word-aligned address, byte enables and lane-replicated store data, and runs a req/gnt + rvalid handshake against a multi-cycle data memory. For loads it extracts the addressed byte or halfword and sign- or zero-extends it before returning a one-cycle response. It sits between the pipeline's MEM stage and the data-memory port and provides the stall (`req_ready`) for that stage.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory initiator with alignment check,
// byte-lane steering for stores and sign/zero extension for loads.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rd,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic              is_load_q, is_load_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              misaligned_q, misaligned_d;

  logic              accept, acc_byte, acc_half, mis_in;
  logic [BE_W-1:0]   be_in;
  logic [DATA_W-1:0] wdata_in, rdata_sh, load_val;

  // Decode the incoming request: stores only know B/H/W, loads add BU/HU
  always_comb begin : req_decode
    accept   = req_valid && (MemRead || MemWrite);
    acc_byte = (Funct3 == 3'b000) || (MemRead && (Funct3 == 3'b100));
    acc_half = (Funct3 == 3'b001) || (MemRead && (Funct3 == 3'b101));
    mis_in   = acc_half ? addr[0] : (!acc_byte && (addr[1:0] != 2'b00));
    if (acc_byte) begin
      be_in    = BE_W'(1) << addr[1:0];
      wdata_in = {(BE_W){wd[7:0]}};
    end else if (acc_half) begin
      be_in    = addr[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
      wdata_in = {(BE_W/2){wd[15:0]}};
    end else begin
      be_in    = {BE_W{1'b1}};
      wdata_in = wd;
    end
  end

  // Shift the addressed lane down to bit 0, then extend
  always_comb begin : load_extract
    rdata_sh = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{(DATA_W-8){rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, rdata_sh[7:0]};
      3'b001:  load_val = {{(DATA_W-16){rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_val = {{(DATA_W-16){1'b0}}, rdata_sh[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin : fsm_next
    state_d      = state_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    is_load_d    = is_load_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    rd_d         = rd_q;
    misaligned_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d  = Funct3;
          lane_d    = addr[1:0];
          is_load_d = MemRead;
          if (mis_in) begin
            state_d      = S_RESP;
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_we_d    = !MemRead;
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = be_in;
            mem_wdata_d = wdata_in;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (is_load_q) rd_d = load_val;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered views of the next state
    req_ready_d = (state_d == S_IDLE);
    mem_req_d   = (state_d == S_REQ);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      is_load_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      is_load_q    <= is_load_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rd_q         <= rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rd         = rd_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, random
// memory latencies, decoupled driver / memory responder / response monitor.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] addr, wd;
  logic        rsp_valid, misaligned;
  logic [31:0] rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .addr(addr), .wd(wd),
    .rsp_valid(rsp_valid), .rd(rd), .misaligned(misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          mis;
    logic [31:0] rd;
    int          acc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gd;
    int          rvd;
  } mem_t;

  rsp_t exp_rsp_q[$];
  mem_t exp_mem_q[$];

  logic [7:0]  rmem[64];   // reference model: byte-addressed memory
  logic [31:0] dmem[16];   // responder's word memory, written via DUT byte enables
  logic [31:0] last_rd = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int unsigned acc_size(input bit ld, input logic [2:0] f3);
    if (ld) begin
      case (f3)
        3'b000, 3'b100: return 1;
        3'b001, 3'b101: return 2;
        default:        return 4;
      endcase
    end
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'h1);
    chk({tag, "_mem_req"},    32'(mem_req),    32'h0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'h0);
    chk({tag, "_mem_addr"},   mem_addr,        32'h0);
    chk({tag, "_mem_be"},     32'(mem_be),     32'h0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'h0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'h0);
    chk({tag, "_rd"},         rd,              32'h0);
    chk({tag, "_misaligned"}, 32'(misaligned), 32'h0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) fail_now("idle_timeout");
  endtask

  // Issue one request from IDLE; expectations come from the byte-level model
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w,
                       input int gd, input int rvd, input bit want_rsp,
                       output int acc);
    int unsigned sz;
    int          base;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wexp, val;
    rsp_t        r;
    mem_t        m;
    wait_idle();
    sz   = acc_size(ld, f3);
    base = int'(a[5:0]);
    mis  = (int'(a[1:0]) % sz) != 0;
    be   = 4'h0;
    val  = 32'h0;
    for (int L = 0; L < 4; L++) wexp[8*L +: 8] = w[8*(L % sz) +: 8];
    if (!mis) begin
      for (int k = 0; k < int'(sz); k++) be[int'(a[1:0]) + k] = 1'b1;
      if (ld) begin
        for (int k = 0; k < int'(sz); k++) val[8*k +: 8] = rmem[base + k];
        if ((f3 == 3'b000 || f3 == 3'b001) && val[8*sz-1])
          val = val | ~((32'd1 << (8*sz)) - 32'd1);
        last_rd = val;
      end else begin
        for (int k = 0; k < int'(sz); k++) rmem[base + k] = w[8*k +: 8];
      end
      m.addr = {a[31:2], 2'b00}; m.we = !ld; m.be = be; m.wdata = wexp;
      m.gd = gd; m.rvd = rvd;
      exp_mem_q.push_back(m);
    end
    acc = cyc;
    if (want_rsp) begin
      r.mis = mis; r.rd = last_rd; r.acc = acc;
      r.lat = mis ? 1 : 3 + gd + rvd;
      exp_rsp_q.push_back(r);
    end
    req_valid = 1'b1; MemRead = ld; MemWrite = st; Funct3 = f3; addr = a; wd = w;
    @(negedge clk);
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    addr = $urandom; wd = $urandom; Funct3 = 3'($urandom_range(0, 7));
  endtask

  // Memory responder: checks address phase, applies delays, serves data
  initial begin
    mem_t m;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        if (exp_mem_q.size() == 0) begin
          fail_now("unexpected_mem_req");
        end else begin
          m = exp_mem_q.pop_front();
          for (int k = 0; k <= m.gd; k++) begin
            if (k > 0) @(negedge clk);
            chk("mem_req_hold",  32'(mem_req),   32'h1);
            chk("req_ready_low", 32'(req_ready), 32'h0);
            chk("mem_addr",      mem_addr,       m.addr);
            chk("mem_we",        32'(mem_we),    32'(m.we));
            chk("mem_be",        32'(mem_be),    32'(m.be));
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            mem_rvalid = (k < m.gd) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = $urandom;
          end
          mem_gnt = 1'b1;
          @(negedge clk);
          mem_gnt = 1'b0;
          chk("mem_req_drop", 32'(mem_req), 32'h0);
          repeat (m.rvd) @(negedge clk);
          if (m.we) begin
            for (int L = 0; L < 4; L++)
              if (mem_be[L]) dmem[mem_addr[5:2]][8*L +: 8] = mem_wdata[8*L +: 8];
          end else begin
            mem_rdata = dmem[mem_addr[5:2]];
          end
          mem_rvalid = 1'b1;
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT completes
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          fail_now("unexpected_rsp_valid");
        end else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_misaligned", 32'(misaligned), 32'(e.mis));
          chk("rsp_latency",    32'(cyc - e.acc), 32'(e.lat));
          chk("rsp_rd",         rd, e.rd);
        end
      end else if (exp_rsp_q.size() != 0 && (cyc - exp_rsp_q[0].acc) > 60) begin
        fail_now("rsp_timeout");
        void'(exp_rsp_q.pop_front());
      end
    end
  end

  initial begin
    int          acc;
    bit          ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned sz;

    reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'b000; addr = 32'h0; wd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = $urandom;
      for (int b = 0; b < 4; b++) rmem[4*i + b] = dmem[i][8*b +: 8];
    end
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_reset");

    // Directed sequence
    issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 1, acc);
    issue(0, 1, 3'b010, 32'h10, 32'h80FF7F01, 1, 0, 1, acc);
    issue(1, 0, 3'b000, 32'h13, 32'h0, 0, 0, 1, acc);
    wait_idle(); chk("lb_value", rd, 32'hFFFFFF80);
    issue(1, 0, 3'b100, 32'h13, 32'h0, 0, 1, 1, acc);
    wait_idle(); chk("lbu_value", rd, 32'h00000080);
    issue(0, 1, 3'b010, 32'h10, 32'h80011234, 0, 1, 1, acc);
    issue(1, 0, 3'b001, 32'h12, 32'h0, 2, 0, 1, acc);
    wait_idle(); chk("lh_value", rd, 32'hFFFF8001);
    issue(1, 0, 3'b101, 32'h12, 32'h0, 0, 0, 1, acc);
    wait_idle(); chk("lhu_value", rd, 32'h00008001);
    issue(0, 1, 3'b000, 32'h21, 32'h000000AB, 0, 0, 1, acc);
    issue(0, 1, 3'b001, 32'h22, 32'h00001234, 0, 0, 1, acc);
    issue(1, 0, 3'b010, 32'h22, 32'h0, 0, 0, 1, acc);
    wait_idle(); chk("misaligned_rd_held", rd, 32'h00008001);
    issue(1, 0, 3'b010, 32'h20, 32'h0, 3, 2, 1, acc);

    // A strobe with neither read nor write must be ignored
    wait_idle();
    req_valid = 1'b1; addr = 32'h30;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ignored_req_ready", 32'(req_ready), 32'h1);
    chk("ignored_mem_req",   32'(mem_req),   32'h0);

    // Reset while waiting for rvalid: transaction aborted, late rvalid ignored
    issue(1, 0, 3'b010, 32'h24, 32'h0, 3, 2, 0, acc);
    repeat (4) @(negedge clk);
    chk("pre_abort_req_ready", 32'(req_ready), 32'h0);
    chk("pre_abort_mem_req",   32'(mem_req),   32'h0);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    last_rd = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      ld = $urandom_range(0, 9) < 6;
      st = ld ? ($urandom_range(0, 3) == 0) : 1'b1;
      f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      a  = $urandom;
      sz = acc_size(ld, f3);
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      if (ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) a[1:0] = 2'b00;
      issue(ld, st, f3, a, $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1, acc);
    end

    wait_idle();
    repeat (10) @(negedge clk);
    chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'h0);
    chk("mem_queue_drained", 32'(exp_mem_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
